mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 132 +++++++++++++
 tb/tb_mem_stage.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory pipeline stage: registers the EX buses, extracts and extends load data, holds it across stalls
module mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic [75:0] ex_to_mem_bus,
  input  logic [2:0]  ex_load_op,
  input  logic [65:0] hilo_ex_to_mem_bus,
  input  logic [31:0] data_sram_rdata,
  output logic [69:0] mem_to_wb_bus,
  output logic [65:0] hilo_mem_to_wb_bus,
  output logic        mem_wreg,
  output logic [4:0]  mem_waddr,
  output logic [31:0] mem_wdata,
  output logic        mem_hi_we,
  output logic        mem_lo_we,
  output logic [31:0] mem_hi_wdata,
  output logic [31:0] mem_lo_wdata
);

  localparam logic [2:0] LD_LW  = 3'b001;
  localparam logic [2:0] LD_LB  = 3'b010;
  localparam logic [2:0] LD_LBU = 3'b011;
  localparam logic [2:0] LD_LH  = 3'b100;
  localparam logic [2:0] LD_LHU = 3'b101;

  logic [75:0] ex_q;
  logic [65:0] hilo_q;
  logic [2:0]  load_op_q;
  logic [31:0] hold_q;
  logic        rdata_valid_q;

  logic        bubble;
  logic        advance;
  logic        is_load;
  logic [31:0] pc;
  logic        ram_en;
  logic [3:0]  ram_wen;
  logic        sel_rf_res;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] ex_result;
  logic [31:0] word;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_data;
  logic [31:0] rf_wdata;
  logic        unused_stall;

  assign unused_stall = ^{stall[5], stall[2:0]};

  // A bubble (this stage stalled, WB free) wins over both load and hold.
  assign bubble  = stall[3] & ~stall[4];
  assign advance = ~stall[3];

  assign {pc, ram_en, ram_wen, sel_rf_res, rf_we, rf_waddr, ex_result} = ex_q;

  always_comb begin
    is_load = 1'b0;
    if (ram_en && (ram_wen == 4'b0000)) begin
      case (load_op_q)
        LD_LW, LD_LB, LD_LBU, LD_LH, LD_LHU: is_load = 1'b1;
        default:                             is_load = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q          <= '0;
      hilo_q        <= '0;
      load_op_q     <= '0;
      hold_q        <= '0;
      rdata_valid_q <= 1'b0;
    end else if (bubble) begin
      ex_q          <= '0;
      hilo_q        <= '0;
      load_op_q     <= '0;
      hold_q        <= '0;
      rdata_valid_q <= 1'b0;
    end else if (advance) begin
      ex_q          <= ex_to_mem_bus;
      hilo_q        <= hilo_ex_to_mem_bus;
      load_op_q     <= ex_load_op;
      rdata_valid_q <= 1'b0;
    end else if (is_load && !rdata_valid_q) begin
      // SRAM word is only valid in the first cycle; keep it for the rest of the stall.
      hold_q        <= data_sram_rdata;
      rdata_valid_q <= 1'b1;
    end
  end

  assign word = rdata_valid_q ? hold_q : data_sram_rdata;

  always_comb begin
    load_byte = word[7:0];
    case (ex_result[1:0])
      2'b00: load_byte = word[7:0];
      2'b01: load_byte = word[15:8];
      2'b10: load_byte = word[23:16];
      2'b11: load_byte = word[31:24];
      default: load_byte = word[7:0];
    endcase
    load_half = ex_result[1] ? word[31:16] : word[15:0];
  end

  always_comb begin
    load_data = 32'h0;
    case (load_op_q)
      LD_LW:   load_data = word;
      LD_LB:   load_data = {{24{load_byte[7]}}, load_byte};
      LD_LBU:  load_data = {24'h0, load_byte};
      LD_LH:   load_data = {{16{load_half[15]}}, load_half};
      LD_LHU:  load_data = {16'h0, load_half};
      default: load_data = 32'h0;
    endcase
  end

  assign rf_wdata = sel_rf_res ? load_data : ex_result;

  assign mem_to_wb_bus      = {pc, rf_we, rf_waddr, rf_wdata};
  assign hilo_mem_to_wb_bus = hilo_q;

  assign mem_wreg     = rf_we;
  assign mem_waddr    = rf_waddr;
  assign mem_wdata    = rf_wdata;
  assign mem_hi_wdata = hilo_q[65:34];
  assign mem_lo_wdata = hilo_q[33:2];
  assign mem_hi_we    = hilo_q[1];
  assign mem_lo_we    = hilo_q[0];

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed table-driven bench for mem_stage
module tb_mem_stage;

  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic [75:0] ex_to_mem_bus;
  logic [2:0]  ex_load_op;
  logic [65:0] hilo_ex_to_mem_bus;
  logic [31:0] data_sram_rdata;
  logic [69:0] mem_to_wb_bus;
  logic [65:0] hilo_mem_to_wb_bus;
  logic        mem_wreg;
  logic [4:0]  mem_waddr;
  logic [31:0] mem_wdata;
  logic        mem_hi_we;
  logic        mem_lo_we;
  logic [31:0] mem_hi_wdata;
  logic [31:0] mem_lo_wdata;

  int tests_run;
  int tests_failed;

  mem_stage dut (
    .clk                (clk),
    .rst                (rst),
    .stall              (stall),
    .ex_to_mem_bus      (ex_to_mem_bus),
    .ex_load_op         (ex_load_op),
    .hilo_ex_to_mem_bus (hilo_ex_to_mem_bus),
    .data_sram_rdata    (data_sram_rdata),
    .mem_to_wb_bus      (mem_to_wb_bus),
    .hilo_mem_to_wb_bus (hilo_mem_to_wb_bus),
    .mem_wreg           (mem_wreg),
    .mem_waddr          (mem_waddr),
    .mem_wdata          (mem_wdata),
    .mem_hi_we          (mem_hi_we),
    .mem_lo_we          (mem_lo_we),
    .mem_hi_wdata       (mem_hi_wdata),
    .mem_lo_wdata       (mem_lo_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        ram_en;
    logic [3:0]  ram_wen;
    logic        sel;
    logic        rf_we;
    logic [4:0]  waddr;
    logic [31:0] ex_result;
    logic [2:0]  load_op;
    logic [65:0] hilo;
    logic [31:0] rdata;
    logic [31:0] exp_wdata;
  } vec_t;

  vec_t vecs[10];

  function automatic vec_t mk(logic [31:0] pc, logic ram_en, logic [3:0] ram_wen, logic sel,
                              logic rf_we, logic [4:0] waddr, logic [31:0] ex_result,
                              logic [2:0] load_op, logic [65:0] hilo, logic [31:0] rdata,
                              logic [31:0] exp_wdata);
    vec_t v;
    v.pc = pc; v.ram_en = ram_en; v.ram_wen = ram_wen; v.sel = sel; v.rf_we = rf_we;
    v.waddr = waddr; v.ex_result = ex_result; v.load_op = load_op; v.hilo = hilo;
    v.rdata = rdata; v.exp_wdata = exp_wdata;
    return v;
  endfunction

  task automatic chk(input string name, input logic [69:0] act, input logic [69:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    ex_to_mem_bus      = {v.pc, v.ram_en, v.ram_wen, v.sel, v.rf_we, v.waddr, v.ex_result};
    ex_load_op         = v.load_op;
    hilo_ex_to_mem_bus = v.hilo;
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, " wb"}, mem_to_wb_bus, 70'h0);
    chk({name, " hilo"}, {4'h0, hilo_mem_to_wb_bus}, 70'h0);
    chk({name, " fwd"}, {mem_wreg, mem_waddr, mem_wdata, mem_hi_we, mem_lo_we}, 70'h0);
  endtask

  logic [31:0] rnd;

  initial begin
    tests_run = 0;
    tests_failed = 0;
    rst = 1'b1;
    stall = 6'b0;
    ex_to_mem_bus = '0;
    ex_load_op = 3'b0;
    hilo_ex_to_mem_bus = '0;
    data_sram_rdata = 32'h0;

    vecs[0] = mk(32'hBFC0_0000, 1, 4'h0, 1, 1, 5'd5,  32'h0000_1000, 3'b001, 66'h0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    vecs[1] = mk(32'hBFC0_0004, 1, 4'h0, 1, 1, 5'd6,  32'h0000_1003, 3'b010, 66'h0, 32'h8011_2233, 32'hFFFF_FF80);
    vecs[2] = mk(32'hBFC0_0008, 1, 4'h0, 1, 1, 5'd7,  32'h0000_1003, 3'b011, 66'h0, 32'h8011_2233, 32'h0000_0080);
    vecs[3] = mk(32'hBFC0_000C, 1, 4'h0, 1, 1, 5'd8,  32'h0000_1002, 3'b100, 66'h0, 32'h8001_7FFF, 32'hFFFF_8001);
    vecs[4] = mk(32'hBFC0_0010, 1, 4'h0, 1, 1, 5'd9,  32'h0000_1002, 3'b101, 66'h0, 32'h8001_7FFF, 32'h0000_8001);
    vecs[5] = mk(32'hBFC0_0014, 1, 4'h0, 1, 1, 5'd10, 32'h0000_1000, 3'b100, 66'h0, 32'h8001_7FFF, 32'h0000_7FFF);
    vecs[6] = mk(32'hBFC0_0018, 0, 4'h0, 0, 1, 5'd11, 32'hCAFE_0001, 3'b000,
                 {32'h0000_0005, 32'h0, 1'b1, 1'b0}, 32'h1111_1111, 32'hCAFE_0001);
    vecs[7] = mk(32'hBFC0_001C, 1, 4'h0, 1, 1, 5'd12, 32'h0000_2000, 3'b010,
                 {32'h0, 32'h0000_0077, 1'b0, 1'b1}, 32'h0000_007F, 32'h0000_007F);
    vecs[8] = mk(32'hBFC0_0020, 1, 4'hF, 0, 0, 5'd0,  32'h0000_2000, 3'b000, 66'h0, 32'h5555_5555, 32'h0000_2000);
    vecs[9] = mk(32'hBFC0_0024, 1, 4'h0, 1, 1, 5'd13, 32'h0000_1001, 3'b100, 66'h0, 32'h1234_ABCD, 32'hFFFF_ABCD);

    #12;
    chk_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      stall = 6'b0;
      drive(vecs[i]);
      @(posedge clk);
      #1 data_sram_rdata = vecs[i].rdata;
      #1;
      chk($sformatf("v%0d rf_wdata", i), {38'h0, mem_wdata}, {38'h0, vecs[i].exp_wdata});
      chk($sformatf("v%0d wb_bus", i), mem_to_wb_bus,
          {vecs[i].pc, vecs[i].rf_we, vecs[i].waddr, vecs[i].exp_wdata});
      chk($sformatf("v%0d hilo", i), {4'h0, hilo_mem_to_wb_bus}, {4'h0, vecs[i].hilo});
      chk($sformatf("v%0d fwd_hi", i), {37'h0, mem_hi_we, mem_hi_wdata},
          {37'h0, vecs[i].hilo[1], vecs[i].hilo[65:34]});
    end

    // Load followed by a three-cycle hold with garbage on the SRAM bus.
    @(negedge clk);
    stall = 6'b0;
    drive(mk(32'hBFC0_0100, 1, 4'h0, 1, 1, 5'd3, 32'h0000_3000, 3'b001, 66'h0, 32'h0, 32'h0));
    @(posedge clk);
    #1 data_sram_rdata = 32'h1234_5678;
    #1;
    chk("hold first", {38'h0, mem_wdata}, {38'h0, 32'h1234_5678});
    stall = 6'b011000;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      rnd = $urandom;
      if (rnd == 32'h1234_5678) rnd = 32'hA5A5_A5A5;
      data_sram_rdata = rnd;
      #1;
      chk($sformatf("hold c%0d", c), mem_to_wb_bus, {32'hBFC0_0100, 1'b1, 5'd3, 32'h1234_5678});
    end

    // Bubble while the load is still held.
    stall = 6'b001000;
    @(posedge clk);
    #1;
    chk_all_zero("bubble");

    // Asynchronous reset pulse in the middle of a cycle.
    @(negedge clk);
    stall = 6'b0;
    drive(vecs[0]);
    @(posedge clk);
    #1 data_sram_rdata = 32'hDEAD_BEEF;
    #1;
    chk("pre-rst", {38'h0, mem_wdata}, {38'h0, 32'hDEAD_BEEF});
    rst = 1'b1;
    #1;
    chk_all_zero("async rst");
    rst = 1'b0;
    #1;
    chk_all_zero("post rst");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
